// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and the load/store unit (DM).
// The DM port wins contention unless IF has already lost MAX_IF_STARVE times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_IF_STARVE = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_be_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  // state   | meaning
  // IDLE    | no access in flight; grants issued combinationally
  // BUSY_IF | fetch access driven to memory, waiting for mem_ready
  // BUSY_DM | load/store access driven to memory, waiting for mem_ready
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(MAX_IF_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_IF_STARVE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_wins;

  assign dm_wins = dm_req_i & (~if_req_i | (starve_q < STARVE_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_valid_o  = 1'b0;
    dm_valid_o  = 1'b0;
    if_rdata_o  = if_rdata_q;
    dm_rdata_o  = dm_rdata_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (dm_wins) begin
          dm_gnt_o = 1'b1;
          addr_d   = dm_addr_i;
          we_d     = dm_we_i;
          be_d     = dm_we_i ? dm_be_i : 4'hF;
          wdata_d  = dm_we_i ? dm_wdata_i : '0;
          state_d  = BUSY_DM;
          // dm_wins with if_req set implies starve_q < STARVE_MAX, so this saturates
          if (if_req_i) starve_d = starve_q + CNT_W'(1);
        end else if (if_req_i) begin
          if_gnt_o = 1'b1;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          be_d     = 4'hF;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_ready_i) begin
          state_d = IDLE;
          if (state_q == BUSY_IF) begin
            if_valid_o = 1'b1;
            if_rdata_o = mem_rdata_i;
            if_rdata_d = mem_rdata_i;
          end else begin
            dm_valid_o = 1'b1;
            // stores acknowledge without disturbing the last load value
            if (!we_q) begin
              dm_rdata_o = mem_rdata_i;
              dm_rdata_d = mem_rdata_i;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // reset aborts any access: no grant or completion may escape in the reset cycle
    if (rst_i) begin
      if_gnt_o   = 1'b0;
      dm_gnt_o   = 1'b0;
      if_valid_o = 1'b0;
      dm_valid_o = 1'b0;
      if_rdata_o = if_rdata_q;
      dm_rdata_o = dm_rdata_q;
    end
  end

  assign stall_if_o  = if_req_i & ~if_valid_o;
  assign stall_mem_o = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table on a MAX_IF_STARVE=4 instance plus
// hand sequences for starvation order (instances with limits 4 and 2) and reset mid-access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;

  logic        if_gnt_a, if_valid_a, dm_gnt_a, dm_valid_a, mem_req_a, mem_we_a, stall_if_a, stall_mem_a;
  logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a;
  logic [3:0]  mem_be_a;
  logic        if_gnt_b, if_valid_b, dm_gnt_b, dm_valid_b, mem_req_b, mem_we_b, stall_if_b, stall_mem_b;
  logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_be_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_IF_STARVE(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_a), .if_valid_o(if_valid_a), .if_rdata_o(if_rdata_a),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt_a), .dm_valid_o(dm_valid_a), .dm_rdata_o(dm_rdata_a),
    .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_be_o(mem_be_a), .mem_addr_o(mem_addr_a),
    .mem_wdata_o(mem_wdata_a), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .stall_if_o(stall_if_a), .stall_mem_o(stall_mem_a));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_IF_STARVE(2)) u_b (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_b), .if_valid_o(if_valid_b), .if_rdata_o(if_rdata_b),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt_b), .dm_valid_o(dm_valid_b), .dm_rdata_o(dm_rdata_b),
    .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_be_o(mem_be_b), .mem_addr_o(mem_addr_b),
    .mem_wdata_o(mem_wdata_b), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .stall_if_o(stall_if_b), .stall_mem_o(stall_mem_b));

  typedef struct {
    logic        rst, if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_if_gnt, e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_dm_gnt, e_dm_valid;
    logic [31:0] e_dm_rdata;
    logic        e_mem_req, e_mem_we;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_stall_if, e_stall_mem;
  } vec_t;

  function automatic vec_t mk(
      logic r, logic ir, logic [31:0] ia, logic dr, logic we, logic [3:0] be, logic [31:0] da,
      logic [31:0] wd, logic rdy, logic [31:0] rd,
      logic igt, logic iv, logic [31:0] ird, logic dgt, logic dv, logic [31:0] drd,
      logic mr, logic mwe, logic [3:0] mbe, logic [31:0] ma, logic [31:0] mwd, logic sif, logic smem);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = we; v.dm_be = be;
    v.dm_addr = da; v.dm_wdata = wd; v.mem_ready = rdy; v.mem_rdata = rd;
    v.e_if_gnt = igt; v.e_if_valid = iv; v.e_if_rdata = ird; v.e_dm_gnt = dgt; v.e_dm_valid = dv;
    v.e_dm_rdata = drd; v.e_mem_req = mr; v.e_mem_we = mwe; v.e_mem_be = mbe; v.e_mem_addr = ma;
    v.e_mem_wdata = mwd; v.e_stall_if = sif; v.e_stall_mem = smem;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0;
    dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  // leaves rst asserted at a falling edge; the caller decides when to release it
  task automatic do_reset();
    rst = 1;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs [20];
  byte  ga [6], gb [6], exp_a [6], exp_b [6];
  int   na, nb;

  initial begin
    vecs[0]  = mk(1,0,0,     0,0,0,0,0,              1,32'h1234,     0,0,0,            0,0,0,            0,0,0,0,0,                        0,0);
    vecs[1]  = mk(0,0,0,     0,0,0,0,0,              1,32'h1234,     0,0,0,            0,0,0,            0,0,0,0,0,                        0,0);
    vecs[2]  = mk(0,1,32'h40,0,0,0,0,0,              0,0,            1,0,0,            0,0,0,            0,0,0,0,0,                        1,0);
    vecs[3]  = mk(0,1,32'h40,0,0,0,0,0,              1,32'h00500093, 0,1,32'h00500093, 0,0,0,            1,0,4'hF,32'h40,0,                0,0);
    vecs[4]  = mk(0,0,0,     0,0,0,0,0,              1,32'hFFFF,     0,0,32'h00500093, 0,0,0,            0,0,0,0,0,                        0,0);
    vecs[5]  = mk(0,1,32'h80,1,0,0,32'h100,0,        0,0,            0,0,32'h00500093, 1,0,0,            0,0,0,0,0,                        1,1);
    vecs[6]  = mk(0,1,32'h80,1,0,0,32'h100,0,        0,0,            0,0,32'h00500093, 0,0,0,            1,0,4'hF,32'h100,0,               1,1);
    vecs[7]  = mk(0,1,32'h80,1,0,0,32'h100,0,        1,32'hCAFE0001, 0,0,32'h00500093, 0,1,32'hCAFE0001, 1,0,4'hF,32'h100,0,               1,0);
    vecs[8]  = mk(0,1,32'h80,0,0,0,0,0,              0,0,            1,0,32'h00500093, 0,0,32'hCAFE0001, 0,0,0,0,0,                        1,0);
    vecs[9]  = mk(0,1,32'h80,0,0,0,0,0,              1,32'h11112222, 0,1,32'h11112222, 0,0,32'hCAFE0001, 1,0,4'hF,32'h80,0,                0,0);
    vecs[10] = mk(0,0,0,     1,1,4'h3,32'h200,32'hDEADBEEF, 0,0,     0,0,32'h11112222, 1,0,32'hCAFE0001, 0,0,0,0,0,                        0,1);
    vecs[11] = mk(0,0,0,     1,1,4'h3,32'h200,32'hDEADBEEF, 0,0,     0,0,32'h11112222, 0,0,32'hCAFE0001, 1,1,4'h3,32'h200,32'hDEADBEEF,  0,1);
    vecs[12] = vecs[11];
    vecs[13] = vecs[11];
    vecs[14] = mk(0,0,0,     1,1,4'h3,32'h200,32'hDEADBEEF, 1,32'h55555555, 0,0,32'h11112222, 0,1,32'hCAFE0001, 1,1,4'h3,32'h200,32'hDEADBEEF, 0,0);
    vecs[15] = mk(0,0,0,     0,0,0,0,0,              0,0,            0,0,32'h11112222, 0,0,32'hCAFE0001, 0,0,0,0,0,                        0,0);
    vecs[16] = mk(0,1,32'h44,0,0,0,0,0,              0,0,            1,0,32'h11112222, 0,0,32'hCAFE0001, 0,0,0,0,0,                        1,0);
    vecs[17] = mk(0,0,32'h99,0,0,0,0,0,              0,0,            0,0,32'h11112222, 0,0,32'hCAFE0001, 1,0,4'hF,32'h44,0,                0,0);
    vecs[18] = mk(0,0,32'h99,0,0,0,0,0,              1,32'h77,       0,1,32'h77,       0,0,32'hCAFE0001, 1,0,4'hF,32'h44,0,                0,0);
    vecs[19] = mk(0,0,0,     0,0,0,0,0,              0,0,            0,0,32'h77,       0,0,32'hCAFE0001, 0,0,0,0,0,                        0,0);

    // table: reset, fetch, contention, wait-stated store, requester dropping req after grant
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_be = vecs[i].dm_be;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
      #1;
      chk($sformatf("v%0d if_gnt", i),    {31'b0, if_gnt_a},    {31'b0, vecs[i].e_if_gnt});
      chk($sformatf("v%0d if_valid", i),  {31'b0, if_valid_a},  {31'b0, vecs[i].e_if_valid});
      chk($sformatf("v%0d if_rdata", i),  if_rdata_a,           vecs[i].e_if_rdata);
      chk($sformatf("v%0d dm_gnt", i),    {31'b0, dm_gnt_a},    {31'b0, vecs[i].e_dm_gnt});
      chk($sformatf("v%0d dm_valid", i),  {31'b0, dm_valid_a},  {31'b0, vecs[i].e_dm_valid});
      chk($sformatf("v%0d dm_rdata", i),  dm_rdata_a,           vecs[i].e_dm_rdata);
      chk($sformatf("v%0d mem_req", i),   {31'b0, mem_req_a},   {31'b0, vecs[i].e_mem_req});
      chk($sformatf("v%0d mem_we", i),    {31'b0, mem_we_a},    {31'b0, vecs[i].e_mem_we});
      chk($sformatf("v%0d mem_be", i),    {28'b0, mem_be_a},    {28'b0, vecs[i].e_mem_be});
      chk($sformatf("v%0d mem_addr", i),  mem_addr_a,           vecs[i].e_mem_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata_a,          vecs[i].e_mem_wdata);
      chk($sformatf("v%0d stall_if", i),  {31'b0, stall_if_a},  {31'b0, vecs[i].e_stall_if});
      chk($sformatf("v%0d stall_mem", i), {31'b0, stall_mem_a}, {31'b0, vecs[i].e_stall_mem});
      @(negedge clk);
    end

    // starvation: both requests held, memory always ready; grant order per instance
    exp_a = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
    exp_b = '{8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h49};
    ga = '{default: 8'h00};
    gb = '{default: 8'h00};
    na = 0; nb = 0;
    do_reset();
    rst = 0; if_req = 1; if_addr = 32'h1000; dm_req = 1; dm_we = 0; dm_addr = 32'h2000; mem_ready = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (na < 6 && dm_gnt_a) begin ga[na] = 8'h44; na++; end
      if (na < 6 && if_gnt_a) begin ga[na] = 8'h49; na++; end
      if (nb < 6 && dm_gnt_b) begin gb[nb] = 8'h44; nb++; end
      if (nb < 6 && if_gnt_b) begin gb[nb] = 8'h49; nb++; end
      @(negedge clk);
    end
    chk("starve4 grant count", na, 6);
    chk("starve2 grant count", nb, 6);
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("starve4 grant%0d", g), {24'b0, ga[g]}, {24'b0, exp_a[g]});
      chk($sformatf("starve2 grant%0d", g), {24'b0, gb[g]}, {24'b0, exp_b[g]});
    end

    // reset while a load waits on memory
    do_reset();
    rst = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_ready = 0;
    #1;
    chk("rstmid dm_gnt", {31'b0, dm_gnt_a}, 32'd1);
    @(negedge clk);
    #1;
    chk("rstmid busy mem_req", {31'b0, mem_req_a}, 32'd1);
    chk("rstmid busy mem_addr", mem_addr_a, 32'h300);
    @(negedge clk);
    rst = 1; dm_req = 0; mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("rstmid rst dm_valid", {31'b0, dm_valid_a}, 32'd0);
    chk("rstmid rst dm_rdata", dm_rdata_a, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rstmid after mem_req", {31'b0, mem_req_a}, 32'd0);
    chk("rstmid after dm_valid", {31'b0, dm_valid_a}, 32'd0);
    chk("rstmid after mem_addr", mem_addr_a, 32'd0);
    @(negedge clk);
    #1;
    chk("rstmid idle dm_valid", {31'b0, dm_valid_a}, 32'd0);
    chk("rstmid idle dm_rdata", dm_rdata_a, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
